rgmii_rx_decode: RTL

Decodes the registered RGMII receive samples produced by the source-synchronous DDR input stage into a GMII-style byte stream with a clock-enable strobe. Its input is the 5-bit {ctl, rxd[3:0]} rising/falling sample pair. It also extracts RGMII in-band link status and counts receive error beats. It sits between the DDR input stage and the MAC receive path, entirely in the recovered RX clock domain.

---
 rtl/rgmii_rx_decode.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: turns the registered RGMII DDR sample pair into a GMII-style
// byte stream with a beat strobe. It also filters RGMII in-band link status and
// counts receive error beats. Everything runs in the recovered RX clock domain.
//
// Ports:
//   clk, rst          recovered RX clock, synchronous active-high reset
//   speed[1:0]        configured speed (10 = 1000M, 01 = 100M, 00 = 10M, 11 = 1000M)
//   rgmii_q1[4:0]     rising-edge sample  {ctl, d[3:0]}
//   rgmii_q2[4:0]     falling-edge sample {ctl, d[3:0]}
//   gmii_rxd[7:0]     received byte
//   gmii_rx_dv        data valid
//   gmii_rx_er        receive error
//   gmii_rx_ce        beat strobe; the other gmii_* outputs are meaningful only when it is 1
//   link_up, link_speed[1:0], link_full_duplex   filtered in-band status
//   rx_error_count[15:0]   saturating count of error beats
//
// Parameter LINK_FILTER (1..15): number of consecutive identical status samples
// needed before link_* update.
// Macro RGMII_RX_ERR_CNT_EN: when defined, the error counter is built. When it is
// undefined, rx_error_count is tied to zero.
module rgmii_rx_decode #(
   parameter int unsigned LINK_FILTER = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  speed,
   input  logic [4:0]  rgmii_q1,
   input  logic [4:0]  rgmii_q2,
   output logic [7:0]  gmii_rxd,
   output logic        gmii_rx_dv,
   output logic        gmii_rx_er,
   output logic        gmii_rx_ce,
   output logic        link_up,
   output logic [1:0]  link_speed,
   output logic        link_full_duplex,
   output logic [15:0] rx_error_count
);

   localparam int unsigned RUN_W = 4;
   localparam int unsigned CNT_W = 16;
   localparam logic [RUN_W-1:0] RUN_MAX  = '1;
   localparam logic [RUN_W-1:0] LINK_THR = RUN_W'(LINK_FILTER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       eff_speed;
   logic             armed;
   logic [3:0]       low_nib;
   logic             low_er;
   logic [3:0]       stat_prev;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_next;

   logic       dv;
   logic       er;
   logic       gig;
   logic       status_ok;
   logic [3:0] nib;

   assign dv        = rgmii_q1[4];
   assign er        = rgmii_q1[4] ^ rgmii_q2[4];
   assign nib       = rgmii_q1[3:0];
   assign gig       = (eff_speed == 2'b10) || (eff_speed == 2'b11);
   assign status_ok = ~rgmii_q1[4] & ~rgmii_q2[4];

   // Run length of identical status samples, saturating so it never wraps back to the threshold
   always_comb begin
      run_next = RUN_W'(1);
      if (nib == stat_prev)
         run_next = (run == RUN_MAX) ? run : run + RUN_W'(1);
   end

   // Speed latch, nibble pairing FSM and registered GMII outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         eff_speed  <= 2'b10;
         armed      <= 1'b0;
         low_nib    <= 4'h0;
         low_er     <= 1'b0;
         gmii_rxd   <= 8'h00;
         gmii_rx_dv <= 1'b0;
         gmii_rx_er <= 1'b0;
         gmii_rx_ce <= 1'b0;
      end else begin
         // Speed follows the configuration only between frames; armed waits for a
         // dv low so that a frame already in progress at reset release is ignored.
         if (!dv) begin
            eff_speed <= speed;
            armed     <= 1'b1;
         end

         if (dv && !armed) begin
            gmii_rx_ce <= 1'b0;
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
            state      <= IDLE;
         end else if (gig) begin
            gmii_rxd   <= {rgmii_q2[3:0], nib};
            gmii_rx_dv <= dv;
            gmii_rx_er <= er;
            gmii_rx_ce <= 1'b1;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (dv) begin
                     // First nibble of a frame is always the low nibble
                     low_nib    <= nib;
                     low_er     <= er;
                     gmii_rx_ce <= 1'b0;
                     state      <= HI;
                  end else begin
                     gmii_rxd   <= {4'h0, nib};
                     gmii_rx_dv <= 1'b0;
                     gmii_rx_er <= er;
                     gmii_rx_ce <= ~gmii_rx_ce;
                  end
               end
               HI: begin
                  gmii_rx_dv <= 1'b1;
                  gmii_rx_ce <= 1'b1;
                  if (dv) begin
                     gmii_rxd   <= {nib, low_nib};
                     gmii_rx_er <= er | low_er;
                     state      <= LO;
                  end else begin
                     // Frame ended on an odd nibble: flush it flagged as an error
                     gmii_rxd   <= {4'h0, low_nib};
                     gmii_rx_er <= 1'b1;
                     state      <= IDLE;
                  end
               end
               LO: begin
                  gmii_rx_ce <= 1'b0;
                  if (dv) begin
                     low_nib <= nib;
                     low_er  <= er;
                     state   <= HI;
                  end else begin
                     state   <= IDLE;
                  end
               end
               default: begin
                  gmii_rx_ce <= 1'b0;
                  state      <= IDLE;
               end
            endcase
         end
      end
   end

   // In-band status filter; frame and error cycles leave it untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_prev        <= 4'h0;
         run              <= '0;
         link_up          <= 1'b0;
         link_speed       <= 2'b00;
         link_full_duplex <= 1'b0;
      end else if (status_ok) begin
         stat_prev <= nib;
         run       <= run_next;
         if (run_next == LINK_THR) begin
            link_up          <= nib[0];
            link_speed       <= nib[2:1];
            link_full_duplex <= nib[3];
         end
      end
   end

`ifdef RGMII_RX_ERR_CNT_EN
   // Counts error beats as they leave the block, sticking at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         rx_error_count <= '0;
      else if (gmii_rx_ce && gmii_rx_dv && gmii_rx_er && (rx_error_count != '1))
         rx_error_count <= rx_error_count + CNT_W'(1);
   end
`else
   assign rx_error_count = 16'h0000;
`endif

endmodule
